// File: rtl/small_mul_acc4591.sv
// small_mul_acc4591: ternary x Rq streaming dot product, exact 28-bit sum.
// Optional input range check enabled by SMALL_MUL_ACC_RANGE_CHECK_EN.
module small_mul_acc4591 #(
  parameter int N_TERMS = 761,
  parameter int CNT_W   = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_a,
  input  logic [1:0]       in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Out,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } slot_e;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_TERMS - 1);

  slot_e            r_slot;
  slot_e            w_slot_nxt;
  logic [27:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_out;

  logic             w_last;
  logic             w_fire;
  logic             w_load;
  logic             w_ofire;
  logic             w_full;
  logic [27:0]      w_a;
  logic [27:0]      w_term;
  logic [27:0]      w_sum;

  assign w_full  = (r_slot == S_FULL);
  assign w_last  = (r_cnt == LAST);
  // Stall only when the last term would clobber an unread sum.
  assign in_ready = !clr &&
    !(w_full && !out_ready && w_last);
  assign w_fire  = in_valid && in_ready;
  assign w_load  = w_fire && w_last;
  assign w_ofire = w_full && out_ready;

  assign w_a = {{15{in_a[12]}}, in_a};

  always_comb begin
    w_term = '0;
    unique case (in_f)
      2'b01:   w_term = w_a;
      2'b11:   w_term = -w_a;
      default: w_term = '0;
    endcase
  end

  assign w_sum = r_acc + w_term;

  always_comb begin
    w_slot_nxt = r_slot;
    unique case (r_slot)
      S_EMPTY:
        if (w_load) w_slot_nxt = S_FULL;
      S_FULL:
        if (w_ofire && !w_load)
          w_slot_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_slot <= S_EMPTY;
    end else begin
      r_slot <= w_slot_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_out <= '0;
    end else if (w_load) begin
      r_out <= {{4{w_sum[27]}}, w_sum};
    end
  end

  assign out_valid = w_full;
  assign Out       = r_out;
  assign cnt       = r_cnt;

`ifdef SMALL_MUL_ACC_RANGE_CHECK_EN
  logic w_bad;
  logic r_err;

  assign w_bad =
    ($signed(in_a) > 13'sd2295) ||
    ($signed(in_a) < -13'sd2295) ||
    (in_f == 2'b10);

  // Sticky until Reset; clr leaves it alone.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_err <= 1'b0;
    end else if (w_fire && w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_small_mul_acc4591.sv
// Bench for small_mul_acc4591: a 761-term and a 4-term instance,
// scoreboard of expected sums checked on every output fire.
module tb_small_mul_acc4591;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic        b_clr = 0, b_iv = 0, b_ir;
  logic        b_ov, b_or = 1, b_err;
  logic [12:0] b_a = '0;
  logic [1:0]  b_f = '0;
  logic [31:0] b_out;
  logic [9:0]  b_cnt;

  logic        s_clr = 0, s_iv = 0, s_ir;
  logic        s_ov, s_or = 1, s_err;
  logic [12:0] s_a = '0;
  logic [1:0]  s_f = '0;
  logic [31:0] s_out;
  logic [2:0]  s_cnt;

  small_mul_acc4591 #(
    .N_TERMS(761),
    .CNT_W  (10)
  ) u_big (
    .Clk      (clk),
    .Reset    (rst_n),
    .clr      (b_clr),
    .in_valid (b_iv),
    .in_ready (b_ir),
    .in_a     (b_a),
    .in_f     (b_f),
    .out_valid(b_ov),
    .out_ready(b_or),
    .Out      (b_out),
    .cnt      (b_cnt),
    .err      (b_err)
  );

  small_mul_acc4591 #(
    .N_TERMS(4),
    .CNT_W  (3)
  ) u_small (
    .Clk      (clk),
    .Reset    (rst_n),
    .clr      (s_clr),
    .in_valid (s_iv),
    .in_ready (s_ir),
    .in_a     (s_a),
    .in_f     (s_f),
    .out_valid(s_ov),
    .out_ready(s_or),
    .Out      (s_out),
    .cnt      (s_cnt),
    .err      (s_err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int q0[$];
  int q1[$];
  int macc[2] = '{0, 0};
  int mcnt[2] = '{0, 0};
  int nt[2]   = '{761, 4};
  logic exp_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    macc = '{0, 0};
    mcnt = '{0, 0};
  endtask

  // Present one term, wait (bounded) for acceptance, update model.
  task automatic term(input bit sm, input int a,
                      input logic [1:0] f);
    int  t;
    bit  ok;
    t = (f == 2'b01) ? a : (f == 2'b11) ? -a : 0;
    if (sm) begin
      s_iv = 1; s_a = 13'(a); s_f = f;
    end else begin
      b_iv = 1; b_a = 13'(a); b_f = f;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = sm ? s_ir : b_ir;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    chk(sm ? "s_accept" : "b_accept", 32'(ok), 1);
    if (ok) begin
      macc[sm] += t;
      mcnt[sm]++;
      if (mcnt[sm] == nt[sm]) begin
        if (sm) q1.push_back(macc[sm]);
        else    q0.push_back(macc[sm]);
        macc[sm] = 0;
        mcnt[sm] = 0;
      end
    end
  endtask

  task automatic rand_term(input bit sm);
    int a;
    int fs;
    logic [1:0] f;
    a  = int'($urandom_range(0, 4590)) - 2295;
    fs = int'($urandom_range(0, 2));
    f  = (fs == 0) ? 2'b00 :
         (fs == 1) ? 2'b01 : 2'b11;
    term(sm, a, f);
  endtask

  always @(negedge clk) begin
    if (rst_n && b_ov && b_or) begin
      chk("b_pending", 32'(q0.size() != 0), 1);
      if (q0.size() != 0)
        chk("b_sum", b_out, 32'(q0.pop_front()));
    end
    if (rst_n && s_ov && s_or) begin
      chk("s_pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0)
        chk("s_sum", s_out, 32'(q1.pop_front()));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SMALL_MUL_ACC_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_out", b_out, 0);
    chk("rst_ov", 32'(b_ov), 0);
    chk("rst_cnt", 32'(b_cnt), 0);
    chk("rst_err", 32'(b_err), 0);
    chk("rst_ir", 32'(b_ir), 1);
    chk("rst_s_ov", 32'(s_ov), 0);
    chk("rst_s_ir", 32'(s_ir), 1);
    @(posedge clk);
    #1;

    // Full-scale positive and negative blocks.
    repeat (761) term(0, 2295, 2'b01);
    b_iv = 0;
    @(negedge clk);
    chk("pos_ov", 32'(b_ov), 1);
    chk("pos_out", b_out, 32'h001AA63F);
    chk("pos_cnt", 32'(b_cnt), 0);
    @(posedge clk);
    #1;
    repeat (761) term(0, 2295, 2'b11);
    b_iv = 0;
    @(negedge clk);
    chk("neg_out", b_out, 32'hFFE559C1);
    @(posedge clk);
    #1;

    // Alternating pattern on the 4-term instance.
    for (int i = 0; i < 8; i++) begin
      term(1, (i % 2 == 0) ? 100 : -7,
           (i % 5 == 4) ? 2'b00 :
           (i % 2 == 0) ? 2'b01 : 2'b11);
      if (i == 3) chk("alt_cnt", 32'(s_cnt), 0);
    end
    s_iv = 0;
    @(negedge clk);
    chk("alt_out", s_out, 114);
    @(posedge clk);
    #1;

    // Back-pressure on the 4-term instance.
    s_or = 0;
    for (int i = 0; i < 4; i++)
      term(1, i * 10 + 1, 2'b01);
    for (int i = 0; i < 3; i++)
      term(1, 5, 2'b11);
    @(negedge clk);
    chk("bp_cnt", 32'(s_cnt), 3);
    chk("bp_ir", 32'(s_ir), 0);
    chk("bp_hold", s_out, 64);
    @(posedge clk);
    #1;
    s_or = 1;
    term(1, 5, 2'b11);
    s_or = 0;
    s_iv = 0;
    @(negedge clk);
    chk("bp_ov", 32'(s_ov), 1);
    chk("bp_new", s_out, 32'hFFFFFFEC);
    @(posedge clk);
    #1;
    s_or = 1;
    repeat (2) @(posedge clk);
    #1;

    // clr at cnt=500 with a held sum pending.
    b_or = 0;
    repeat (761) rand_term(0);
    repeat (500) rand_term(0);
    b_clr = 1;
    b_iv  = 1;
    b_a   = 13'd77;
    b_f   = 2'b01;
    @(negedge clk);
    chk("clr_cnt", 32'(b_cnt), 500);
    chk("clr_ir", 32'(b_ir), 0);
    @(posedge clk);
    #1;
    b_clr = 0;
    b_iv  = 0;
    macc[0] = 0;
    mcnt[0] = 0;
    @(negedge clk);
    chk("clr_cnt0", 32'(b_cnt), 0);
    chk("clr_ov", 32'(b_ov), 1);
    @(posedge clk);
    #1;
    b_or = 1;
    repeat (761) rand_term(0);
    b_iv = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a block.
    repeat (100) term(0, 9, 2'b01);
    rst_n = 0;
    b_iv  = 0;
    model_reset();
    @(negedge clk);
    chk("mid_cnt", 32'(b_cnt), 0);
    chk("mid_ov", 32'(b_ov), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (761) term(0, 1, 2'b01);
    b_iv = 0;
    @(negedge clk);
    chk("mid_out", b_out, 761);
    @(posedge clk);
    #1;

    // Range error flag.
    term(0, 2296, 2'b01);
    b_iv = 0;
    term(1, 5, 2'b10);
    s_iv = 0;
    @(negedge clk);
    chk("err_a", 32'(b_err), 32'(exp_err));
    chk("err_f", 32'(s_err), 32'(exp_err));
    @(posedge clk);
    #1;
    b_clr = 1;
    @(posedge clk);
    #1;
    b_clr = 0;
    @(negedge clk);
    chk("err_clr", 32'(b_err), 32'(exp_err));
    @(posedge clk);
    #1;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    chk("err_rst", 32'(b_err), 0);
    chk("err_rst_s", 32'(s_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) @(posedge clk);

    chk("b_drained", 32'(q0.size()), 0);
    chk("s_drained", 32'(q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/small_mul_acc4591.md
# small_mul_acc4591

Streaming dot-product engine for the decapsulation datapath. It multiplies an Rq coefficient stream by a ternary (small) polynomial row and accumulates N_TERMS products into one signed sum. The sum is presented as a 32-bit signed word that feeds the signed 4591 reducer (`modmul4591S`) input directly. Used for the c·f style products, where one operand is in {-1,0,+1}.

## Interface

Parameters:

- `N_TERMS`, 761: terms per output sum; legal range 2..1023.
- `CNT_W`, 10: term-counter width; must satisfy 2^CNT_W ≥ N_TERMS.

Ports (reset is asynchronous, active-low, on `Reset`):

- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous abort of the block in progress.
- `in_valid`  in  1  term present.
- `in_ready`  out  1  term can be accepted.
- `in_a`  in  13  signed Rq coefficient, nominal [-2295, 2295].
- `in_f`  in  2  ternary weight: 00 = 0, 01 = +1, 11 = -1, 10 = reserved (weight 0).
- `out_valid`  out  1  sum held in `Out`.
- `out_ready`  in  1  downstream accepts `Out`.
- `Out`  out  32  signed sum, sign-extended from 28 bits.
- `cnt`  out  CNT_W  terms accepted in the current block.
- `err`  out  1  sticky input-range error (see Configuration).

## Operation

- Term fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- Term value: +`in_a`, -`in_a`, or 0, selected by `in_f`.
  - Sign-extend to 28 bits before add/negate.
  - -(-4096) is not a legal input; out-of-range handling is covered by `err`.
- Accumulator `acc` (28-bit signed):
  - On a non-last term fire: `acc <= acc + term`, `cnt <= cnt + 1`.
  - On the last term fire (`cnt == N_TERMS-1`): `Out <= sext32(acc + term)`, `out_valid <= 1`, `acc <= 0`, `cnt <= 0`.
- Output slot is a single register with states EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - FULL → EMPTY on output fire, unless a last-term fire occurs in the same cycle; then the slot stays FULL with the new sum.
  - EMPTY → FULL on last-term fire.
- Accumulation of the next block continues while the slot is FULL.
- `in_ready` = !(`out_valid` && !`out_ready` && `cnt == N_TERMS-1`).
  - The block stalls only when its last term would overwrite an unconsumed sum.
  - `in_ready` depends combinationally on `out_ready`; there is no combinational path from `in_valid`.
- `clr`: `acc <= 0`, `cnt <= 0`.
  - A term presented in the same cycle is discarded; `in_ready` is held 0 while `clr`=1.
  - The held `Out`/`out_valid` are untouched.
- Arithmetic: |sum| ≤ 1023·4095 < 2^27, so no overflow handling is needed; the result is exact, not reduced.

## Timing

- Reset values: `Out`=0, `out_valid`=0, `acc`=0, `cnt`=0, `err`=0. `in_ready` is 1 after reset.
- Latency: `Out`/`out_valid` update on the edge that accepts the last term, so they are visible the next cycle.
- Throughput: one term per cycle; N_TERMS cycles per sum with no bubbles when `out_ready`=1.
- `Out` is stable while `out_valid`=1 and no output fire occurs.
- Reset asserted mid-block:
  - Every register clears immediately (asynchronous).
  - The partial sum is lost.
  - The first fire after deassertion is term 0.

## Configuration

- `SMALL_MUL_ACC_RANGE_CHECK_EN` defined:
  - `err` sets on any term fire with `in_a` > 2295, `in_a` < -2295, or `in_f` == 2'b10.
  - `err` is sticky and clears only on `Reset` (not on `clr`).
  - Datapath behaviour is unchanged.
- Not defined: `err` is tied to 0 and the compare logic is absent.

## Test plan

- Reset, then N_TERMS=761 terms with `in_a`=2295, `in_f`=01, `out_ready`=1 → one cycle after the 761st fire, `out_valid`=1 and `Out`=1746495 (0x001AA63F).
- Same stream with `in_f`=11 → `Out`=-1746495 (0xFFE559C1); through the reducer this gives -1746495 mod± 4591.
- Alternating `in_a`=100/`in_f`=01 and `in_a`=-7/`in_f`=11 (in_f 00 on every 5th term), N_TERMS=4: terms 100, 7, 100, 7 → `Out`=214.
- Back-pressure with N_TERMS=4:
  - Hold `out_ready`=0 after the first sum.
  - Terms 0..2 of the next block are accepted, then `in_ready` drops at `cnt`=3.
  - Raise `out_ready`: the first sum fires and the 4th term is accepted in the same cycle; the next cycle shows the new `Out` with `out_valid`=1.
- Assert `clr` with `in_valid`=1 at `cnt`=500 → `cnt`=0 next cycle, the term is discarded, and the next 761 fires produce a correct fresh sum. An earlier held `Out` is still delivered.
- With the macro: a single term `in_a`=2296 or `in_f`=10 → `err`=1 and stays 1 through `clr`; it clears only on `Reset`=0.
